// File: rtl/taitosj_ram_dma_if.sv
// Control and RAM-port bundle for the Taito SJ RAM DMA engine.
// master = the engine (drives the RAM port), slave = CPU-side regs plus RAM.
interface taitosj_ram_dma_if #(
  parameter int AW = 11,
  parameter int DW = 8
);
  logic          cen;
  logic          start;
  logic          mode;
  logic [AW-1:0] src;
  logic [AW-1:0] dst;
  logic [AW-1:0] len;
  logic [DW-1:0] fill;
  logic          busy;
  logic          done;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_data;
  logic          ram_nWE;
  logic [DW-1:0] ram_q;

  modport master (
    input  cen, start, mode, src, dst, len, fill, ram_q,
    output busy, done, ram_addr, ram_data, ram_nWE
  );

  modport slave (
    output cen, start, mode, src, dst, len, fill, ram_q,
    input  busy, done, ram_addr, ram_data, ram_nWE
  );
endinterface

// File: rtl/taitosj_ram_dma.sv
// Block copy / constant fill engine driving one single-port synchronous RAM.
// Copy costs RD, LAT, WR (three cen cycles) per byte; fill costs one WR per byte.
module taitosj_ram_dma #(
  parameter int AW = 11,
  parameter int DW = 8
) (
  input  logic              clk,
  input  logic              nRESET,
  taitosj_ram_dma_if.master bus
);

  typedef enum logic [1:0] {IDLE, RD, LAT, WR} state_t;

  localparam logic [AW-1:0] ONE = {{(AW-1){1'b0}}, 1'b1};

  state_t        state_q;
  logic          mode_q;
  logic [AW-1:0] src_q, dst_q, cnt_q;
  logic [DW-1:0] fill_q;
  logic          busy_q, done_q, nwe_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] data_q;

  // Pointer and count successors; pointers wrap naturally at 2^AW.
  logic [AW-1:0] src_d, dst_d, cnt_d;
  assign src_d = src_q + ONE;
  assign dst_d = dst_q + ONE;
  assign cnt_d = cnt_q - ONE;

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.ram_addr = addr_q;
  assign bus.ram_data = data_q;
  assign bus.ram_nWE  = nwe_q;

  // Transfer FSM: start sampled every clk while idle, transfer steps gated by cen.
  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET) begin
      state_q <= IDLE;
      mode_q  <= 1'b0;
      src_q   <= '0;
      dst_q   <= '0;
      cnt_q   <= '0;
      fill_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      nwe_q   <= 1'b1;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      // done is a single-clk pulse whatever cen does
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            if (bus.len == '0) begin
              done_q <= 1'b1;
            end else begin
              mode_q <= bus.mode;
              src_q  <= bus.src;
              dst_q  <= bus.dst;
              cnt_q  <= bus.len;
              fill_q <= bus.fill;
              busy_q <= 1'b1;
              if (bus.mode) begin
                state_q <= WR;
                addr_q  <= bus.dst;
                data_q  <= bus.fill;
                nwe_q   <= 1'b0;
              end else begin
                state_q <= RD;
                addr_q  <= bus.src;
                nwe_q   <= 1'b1;
              end
            end
          end
        end
        RD: begin
          // RAM registers the read on this cen edge
          if (bus.cen) state_q <= LAT;
        end
        LAT: begin
          if (bus.cen) begin
            data_q  <= bus.ram_q;
            addr_q  <= dst_q;
            nwe_q   <= 1'b0;
            state_q <= WR;
          end
        end
        WR: begin
          if (bus.cen) begin
            src_q <= src_d;
            dst_q <= dst_d;
            cnt_q <= cnt_d;
            if (cnt_d == '0) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              nwe_q   <= 1'b1;
              addr_q  <= '0;
              data_q  <= '0;
            end else if (mode_q) begin
              addr_q <= dst_d;
            end else begin
              state_q <= RD;
              addr_q  <= src_d;
              nwe_q   <= 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_taitosj_ram_dma.sv
// Bench for taitosj_ram_dma: RAM model on the engine port, byte-level
// reference memory updated with plain forward-copy/fill loops.
module tb_taitosj_ram_dma;
  localparam int AW = 11;
  localparam int DW = 8;
  localparam int N  = 1 << AW;

  logic clk = 1'b0;
  logic nRESET = 1'b0;
  int   cen_mode = 0;   // 0: always 1, 1: toggle 1-of-2, 2: random
  int   vectors = 0;
  int   errs = 0;

  taitosj_ram_dma_if #(.AW(AW), .DW(DW)) bus();

  taitosj_ram_dma #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .nRESET(nRESET), .bus(bus.master)
  );

  always #5 clk = ~clk;

  // cen changes 2ns after the rising edge so tasks see it stable at negedge
  initial begin
    bus.cen = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      case (cen_mode)
        0: bus.cen = 1'b1;
        1: bus.cen = ~bus.cen;
        default: bus.cen = 1'($urandom % 2);
      endcase
    end
  end

  // RAM model with a host port for preloading
  logic [DW-1:0] mem [0:N-1];
  logic [DW-1:0] ref_mem [0:N-1];
  logic [DW-1:0] q_r = '0;
  logic          h_we = 1'b0;
  logic [AW-1:0] h_addr = '0;
  logic [DW-1:0] h_data = '0;
  always @(posedge clk) begin
    if (bus.cen) begin
      if (h_we) mem[h_addr] <= h_data;
      else if (!bus.ram_nWE) mem[bus.ram_addr] <= bus.ram_data;
      q_r <= mem[h_we ? h_addr : bus.ram_addr];
    end
  end
  assign bus.ram_q = q_r;

  // Activity counters sampled at rising edges
  int m_bclk = 0, m_bcen = 0, m_done = 0, m_wr = 0, m_badwe = 0;
  always @(posedge clk) begin
    if (bus.busy) m_bclk++;
    if (bus.busy && bus.cen) m_bcen++;
    if (bus.done) m_done++;
    if (bus.cen && !bus.ram_nWE) m_wr++;
    if (!bus.ram_nWE && !bus.busy) m_badwe++;
  end
  int s_bclk, s_bcen, s_done, s_wr, s_badwe;

  task automatic host_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    h_we = 1'b1; h_addr = a; h_data = d;
    ref_mem[a] = d;
    @(negedge clk);
    h_we = 1'b0;
  endtask

  task automatic apply_model(input bit m, input logic [AW-1:0] s, input logic [AW-1:0] d,
                             input int l, input logic [DW-1:0] f);
    for (int i = 0; i < l; i++) begin
      ref_mem[(int'(d) + i) % N] = m ? f : ref_mem[(int'(s) + i) % N];
    end
  endtask

  // Called at a negedge; raises start for the coming rising edge
  task automatic kick(input bit m, input logic [AW-1:0] s, input logic [AW-1:0] d,
                      input logic [AW-1:0] l, input logic [DW-1:0] f);
    if (cen_mode == 1) while (!bus.cen) @(negedge clk);
    s_bclk = m_bclk; s_bcen = m_bcen; s_done = m_done; s_wr = m_wr; s_badwe = m_badwe;
    bus.mode = m; bus.src = s; bus.dst = d; bus.len = l; bus.fill = f;
    bus.start = 1'b1;
  endtask

  task automatic wait_done(input string nm);
    int t = 0;
    while (!bus.done && t < 30000) begin
      @(negedge clk);
      t++;
    end
    vectors++;
    if (!bus.done) begin
      errs++;
      $display("FAIL %s timeout: done=%0b after %0d clk, required 1", nm, bus.done, t);
    end
  endtask

  task automatic check_stats(input string nm, input int exp_cen, input int exp_wr);
    vectors++;
    if (m_bcen - s_bcen !== exp_cen) begin
      errs++;
      $display("FAIL %s busy cen edges: got %0d required %0d", nm, m_bcen - s_bcen, exp_cen);
    end
    vectors++;
    if (m_wr - s_wr !== exp_wr) begin
      errs++;
      $display("FAIL %s write strobes: got %0d required %0d", nm, m_wr - s_wr, exp_wr);
    end
    vectors++;
    if (m_done - s_done !== 1) begin
      errs++;
      $display("FAIL %s done pulses: got %0d required 1", nm, m_done - s_done);
    end
    vectors++;
    if (m_badwe - s_badwe !== 0) begin
      errs++;
      $display("FAIL %s nWE low while idle: got %0d cycles required 0", nm, m_badwe - s_badwe);
    end
  endtask

  task automatic check_mem(input string nm);
    int bad = 0;
    int first = -1;
    for (int a = 0; a < N; a++) begin
      if (mem[a] !== ref_mem[a]) begin
        bad++;
        if (first < 0) first = a;
      end
    end
    vectors++;
    if (bad != 0) begin
      errs++;
      $display("FAIL %s memory: %0d bytes differ, first at %03h got %02h required %02h",
               nm, bad, first, mem[first], ref_mem[first]);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    vectors++;
    if ({bus.busy, bus.done, bus.ram_nWE, bus.ram_addr, bus.ram_data} !== {3'b001, 11'h0, 8'h0}) begin
      errs++;
      $display("FAIL reset outputs: busy=%0b done=%0b nWE=%0b addr=%03h data=%02h required 0 0 1 000 00",
               bus.busy, bus.done, bus.ram_nWE, bus.ram_addr, bus.ram_data);
    end
    nRESET = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if ({bus.busy, bus.done, bus.ram_nWE} !== 3'b001) begin
      errs++;
      $display("FAIL idle after reset: busy=%0b done=%0b nWE=%0b required 0 0 1",
               bus.busy, bus.done, bus.ram_nWE);
    end
  endtask

  task automatic test_preload();
    for (int a = 0; a < N; a++) host_wr(11'(a), 8'($urandom));
    check_mem("preload");
  endtask

  task automatic test_fill_wrap();
    cen_mode = 0;
    apply_model(1'b1, 11'h0, 11'h7F0, 32, 8'hA5);
    @(negedge clk);
    kick(1'b1, 11'h0, 11'h7F0, 11'h020, 8'hA5);
    @(negedge clk); bus.start = 1'b0;
    wait_done("fill_wrap");
    @(negedge clk);
    check_stats("fill_wrap", 32, 32);
    vectors++;
    if (m_bclk - s_bclk !== 32) begin
      errs++;
      $display("FAIL fill_wrap busy clk: got %0d required 32", m_bclk - s_bclk);
    end
    check_mem("fill_wrap");
  endtask

  task automatic test_copy_half_cen();
    cen_mode = 0;
    host_wr(11'h100, 8'h11); host_wr(11'h101, 8'h22);
    host_wr(11'h102, 8'h33); host_wr(11'h103, 8'h44);
    apply_model(1'b0, 11'h100, 11'h200, 4, 8'h00);
    cen_mode = 1;
    repeat (2) @(negedge clk);
    kick(1'b0, 11'h100, 11'h200, 11'h004, 8'h00);
    @(negedge clk); bus.start = 1'b0;
    wait_done("copy_half");
    @(negedge clk);
    check_stats("copy_half", 12, 4);
    vectors++;
    if (m_bclk - s_bclk !== 24) begin
      errs++;
      $display("FAIL copy_half busy clk: got %0d required 24", m_bclk - s_bclk);
    end
    check_mem("copy_half");
    cen_mode = 0;
  endtask

  task automatic test_overlap();
    cen_mode = 0;
    host_wr(11'h300, 8'h5A);
    apply_model(1'b0, 11'h300, 11'h301, 3, 8'h00);
    @(negedge clk);
    kick(1'b0, 11'h300, 11'h301, 11'h003, 8'h00);
    @(negedge clk); bus.start = 1'b0;
    wait_done("overlap");
    @(negedge clk);
    check_stats("overlap", 9, 3);
    check_mem("overlap");
  endtask

  task automatic test_len0();
    @(negedge clk);
    kick(1'b0, 11'h010, 11'h020, 11'h000, 8'h00);
    @(negedge clk); bus.start = 1'b0;
    wait_done("len0");
    @(negedge clk);
    vectors++;
    if (m_bclk - s_bclk !== 0 || m_done - s_done !== 1 || m_wr - s_wr !== 0 || bus.done !== 1'b0) begin
      errs++;
      $display("FAIL len0: busy clk=%0d done pulses=%0d writes=%0d done now=%0b required 0 1 0 0",
               m_bclk - s_bclk, m_done - s_done, m_wr - s_wr, bus.done);
    end
    check_mem("len0");
  endtask

  task automatic test_ignore_and_back_to_back();
    logic [DW-1:0] f1 = 8'($urandom);
    logic [DW-1:0] f2 = 8'($urandom);
    cen_mode = 0;
    apply_model(1'b1, 11'h0, 11'h600, 40, f1);
    @(negedge clk);
    kick(1'b1, 11'h0, 11'h600, 11'd40, f1);
    @(negedge clk); bus.start = 1'b0;
    repeat (10) @(negedge clk);
    bus.start = 1'b1; bus.mode = 1'b0; bus.src = 11'h123; bus.dst = 11'h650; bus.len = 11'd5;
    bus.fill = 8'h00;
    @(negedge clk); bus.start = 1'b0;
    wait_done("ignore_start");
    vectors++;
    if (m_bcen - s_bcen !== 40 || m_wr - s_wr !== 40) begin
      errs++;
      $display("FAIL ignore_start: cen edges=%0d writes=%0d required 40 40", m_bcen - s_bcen, m_wr - s_wr);
    end
    // next start raised while done is still high
    apply_model(1'b1, 11'h0, 11'h700, 8, f2);
    kick(1'b1, 11'h0, 11'h700, 11'd8, f2);
    @(negedge clk); bus.start = 1'b0;
    vectors++;
    if (bus.busy !== 1'b1) begin
      errs++;
      $display("FAIL back_to_back accept: busy=%0b required 1", bus.busy);
    end
    wait_done("back_to_back");
    @(negedge clk);
    check_mem("back_to_back");
  endtask

  task automatic test_reset_mid_copy();
    logic [DW-1:0] f;
    cen_mode = 0;
    apply_model(1'b0, 11'h400, 11'h500, 2, 8'h00);
    @(negedge clk);
    kick(1'b0, 11'h400, 11'h500, 11'd10, 8'h00);
    @(negedge clk); bus.start = 1'b0;
    repeat (7) @(posedge clk);
    #2 nRESET = 1'b0;
    #1;
    vectors++;
    if (bus.ram_nWE !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errs++;
      $display("FAIL async reset: nWE=%0b busy=%0b done=%0b required 1 0 0", bus.ram_nWE, bus.busy, bus.done);
    end
    @(negedge clk);
    @(negedge clk); nRESET = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if (m_done - s_done !== 0) begin
      errs++;
      $display("FAIL reset_mid done pulses: got %0d required 0", m_done - s_done);
    end
    check_mem("reset_mid");
    f = 8'($urandom);
    apply_model(1'b0, 11'h400, 11'h520, 6, f);
    kick(1'b0, 11'h400, 11'h520, 11'd6, f);
    @(negedge clk); bus.start = 1'b0;
    wait_done("after_reset");
    @(negedge clk);
    check_stats("after_reset", 18, 6);
    check_mem("after_reset");
  endtask

  task automatic test_random();
    for (int k = 0; k < 8; k++) begin
      bit m = 1'($urandom % 2);
      logic [AW-1:0] s = 11'($urandom);
      logic [AW-1:0] d = 11'($urandom);
      int l = (k == 7) ? 2000 : int'($urandom_range(1, 64));
      logic [DW-1:0] f = 8'($urandom);
      cen_mode = (k == 7) ? 0 : 2;
      apply_model(m, s, d, l, f);
      @(negedge clk);
      kick(m, s, d, 11'(l), f);
      @(negedge clk); bus.start = 1'b0;
      wait_done("random");
      @(negedge clk);
      check_stats("random", m ? l : 3 * l, l);
      check_mem("random");
    end
    cen_mode = 0;
  endtask

  initial begin
    bus.start = 1'b0; bus.mode = 1'b0; bus.src = '0; bus.dst = '0; bus.len = '0; bus.fill = '0;
    test_reset();
    test_preload();
    test_fill_wrap();
    test_copy_half_cen();
    test_overlap();
    test_len0();
    test_ignore_and_back_to_back();
    test_reset_mid_copy();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule

// File: doc/taitosj_ram_dma.md
# taitosj_ram_dma

Bus-initiator engine for the single-port synchronous RAM models used across the Taito SJ core (cen-gated write, one-cen-cycle registered read). It drives the RAM-side address/data/nWE to perform block copy (RAM to RAM within one array) or constant fill, for example clearing work RAM at boot or moving sprite lists. It sits between the CPU-side control registers (start/parameters) and one RAM instance's port, muxed in by the owner while `busy` is high.

## Interface
- `AW`, 11: RAM address width; the block length and the wrap modulus are 2^AW.
- `DW`, 8: RAM data width.

- `clk`  in  1  system clock, all state on rising edge.
- `nRESET`  in  1  asynchronous, active-low reset.
- `cen`  in  1  RAM clock enable; the engine advances only on `clk` edges with `cen`=1 and presents the same `cen` to the RAM.
- `start`  in  1  request; sampled on every `clk` edge while idle, independent of `cen`.
- `mode`  in  1  0 = copy, 1 = fill; latched at start.
- `src`  in  AW  copy source base; latched at start.
- `dst`  in  AW  destination base; latched at start.
- `len`  in  AW  byte count; 0 = no-op; latched at start.
- `fill`  in  DW  fill value; latched at start.
- `busy`  out  1  high from the accepted start until the last write completes.
- `done`  out  1  one-`clk` pulse at completion.
- `ram_addr`  out  AW  RAM address.
- `ram_data`  out  DW  RAM write data.
- `ram_nWE`  out  1  RAM write strobe, active low.
- `ram_q`  in  DW  RAM registered read data, valid one `cen` edge after the address is presented.

## Operation
- States: IDLE, RD, LAT, WR. All outputs registered.
- IDLE: `ram_nWE`=1, `ram_addr`=0, `ram_data`=0. On `start`=1 with `len`≠0, latch the parameters, set `busy`=1, and enter RD (copy) or WR (fill). On `start`=1 with `len`=0, assert `done` for one clk with `busy` staying 0 and no RAM access.
- RD (copy): `ram_addr`=src pointer, `ram_nWE`=1. On a `cen` edge, go to LAT.
- LAT: address held, `ram_nWE`=1. On a `cen` edge, capture `ram_q` into the data register and go to WR.
- WR: `ram_addr`=dst pointer, `ram_data`=captured byte (copy) or `fill` (fill), `ram_nWE`=0. On a `cen` edge the RAM writes, both pointers increment modulo 2^AW, and the remaining count decrements. If the count reaches 0, go to IDLE with `busy`=0 and `done`=1. Otherwise go to RD (copy) or stay in WR (fill).
- Copy proceeds in ascending byte order, one byte fully written before the next is read. Overlapping regions use these defined forward semantics, with no memmove correction.
- `start` is ignored while `busy`=1. Latched parameters are immune to input changes mid-run.
- When `cen`=0, the state and all outputs hold. `ram_nWE` may stay low across non-cen cycles, because the RAM only writes on cen.

## Timing
- Reset values: `busy`=0, `done`=0, `ram_addr`=0, `ram_data`=0, `ram_nWE`=1, state IDLE. An assertion mid-run aborts immediately (asynchronous); a partially written region is left as is.
- Start to first RAM cycle: `busy` rises on the clk edge that samples `start`. The first RD/WR presentation is in the same cycle.
- Cost: 3 cen cycles per byte for copy, 1 per byte for fill. Total is 3·len or len cen cycles.
- `done` rises on the cen edge that performs the final write, together with `busy` falling. It clears on the next clk edge regardless of `cen`.
- Back-to-back operation: a new `start` is accepted the clk edge after `busy` falls. `start` may be held high across `done`; it is accepted on the first clk edge while `busy`=0 and `done`=1.
- Wrap: a pointer at 2^AW−1 increments to 0. `len` can reach up to 2^AW−1 bytes.

## Test plan
- Fill: `mode`=1, `dst`=0x7F0, `len`=0x20, `fill`=0xA5, `cen`=1 → bytes 0x7F0..0x7FF and 0x000..0x00F read 0xA5, 0x010 unchanged, `busy` high for exactly 32 clk, single `done` pulse.
- Copy with `cen` toggling 1-of-2: preload 0x100..0x103 = 11,22,33,44; `src`=0x100, `dst`=0x200, `len`=4 → 0x200..0x203 = 11,22,33,44 after 12 cen edges (24 clk), `ram_nWE` low only in WR.
- Overlap: 0x300=0x5A, `src`=0x300, `dst`=0x301, `len`=3 → 0x301..0x303 all 0x5A.
- `len`=0 start → `done` for 1 clk, `busy` never high, `ram_nWE` stays 1.
- `start` pulse mid-fill with different `dst` → ignored, original run completes unchanged. Then a second start one clk after `done` → accepted.
- `nRESET` low mid-copy → `ram_nWE`=1 and `busy`=0 asynchronously, no `done`. The next start runs cleanly.
